led_blink_scheduler: RTL

//  Multi-channel LED blink controller built on a single shared prescaler.
//  A host (button FSM, UART cmd decoder, etc.) writes per-channel configs over a valid/ready port.

---
 rtl/led_blink_scheduler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/led_blink_scheduler.sv
// Multi-channel LED blink controller: one shared prescaler tick drives independent
// per-channel OFF/ON/BLINK/PULSE sequencers configured over a valid/ready write port.
module led_blink_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1_000,
  parameter int PER_W   = 16,
  parameter int CNT_W   = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [CH_W-1:0]     i_cfg_ch,
  input  logic [1:0]          i_cfg_mode,
  input  logic [PER_W-1:0]    i_cfg_half_per,
  input  logic [CNT_W-1:0]    i_cfg_count,
  output logic [NUM_CH-1:0]   o_led,
  output logic [NUM_CH-1:0]   o_busy,
  output logic [NUM_CH-1:0]   o_done,
  output logic [3*NUM_CH-1:0] o_state
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRESC_W  = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_ON       = 3'd1,
    S_BLINK_HI = 3'd2,
    S_BLINK_LO = 3'd3,
    S_PULSE_HI = 3'd4,
    S_PULSE_LO = 3'd5
  } ch_state_t;

  logic [PRESC_W-1:0] presc;
  logic               r_tick;
  logic               accept;

  ch_state_t          state_q [NUM_CH];
  logic [PER_W-1:0]   half_q  [NUM_CH];
  logic [PER_W-1:0]   cnt_q   [NUM_CH];
  logic [CNT_W-1:0]   rem_q   [NUM_CH];
  logic [NUM_CH-1:0]  led_q;
  logic [NUM_CH-1:0]  busy_q;
  logic [NUM_CH-1:0]  done_q;

  // Handshake: a write transfers on any cycle where i_cfg_valid && o_cfg_ready.
  // Ready drops only in the r_tick cycle, so a write and tick processing never share a cycle.
  assign o_cfg_ready = ~r_tick;
  assign accept      = i_cfg_valid & ~r_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (presc == PRESC_W'(TICK_DIV - 1));
      presc  <= (presc == PRESC_W'(TICK_DIV - 1)) ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= S_OFF;
        half_q[c]  <= PER_W'(1);
        cnt_q[c]   <= '0;
        rem_q[c]   <= '0;
      end
      led_q  <= '0;
      busy_q <= '0;
      done_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        done_q[c] <= 1'b0;
        // Out-of-range channel numbers match no c, so such writes complete but change nothing.
        if (accept && (32'(i_cfg_ch) == c)) begin
          half_q[c] <= (i_cfg_half_per == '0) ? PER_W'(1) : i_cfg_half_per;
          cnt_q[c]  <= '0;
          rem_q[c]  <= i_cfg_count;
          case (i_cfg_mode)
            2'b00: begin
              state_q[c] <= S_OFF;
              led_q[c]   <= 1'b0;
              busy_q[c]  <= 1'b0;
            end
            2'b01: begin
              state_q[c] <= S_ON;
              led_q[c]   <= 1'b1;
              busy_q[c]  <= 1'b0;
            end
            2'b10: begin
              state_q[c] <= S_BLINK_HI;
              led_q[c]   <= 1'b1;
              busy_q[c]  <= 1'b1;
            end
            default: begin
              if (i_cfg_count != '0) begin
                state_q[c] <= S_PULSE_HI;
                led_q[c]   <= 1'b1;
                busy_q[c]  <= 1'b1;
              end else begin
                state_q[c] <= S_OFF;
                led_q[c]   <= 1'b0;
                busy_q[c]  <= 1'b0;
                done_q[c]  <= 1'b1;
              end
            end
          endcase
        end else if (r_tick && busy_q[c]) begin
          if (cnt_q[c] == half_q[c] - PER_W'(1)) begin
            cnt_q[c] <= '0;
            case (state_q[c])
              S_BLINK_HI: begin
                state_q[c] <= S_BLINK_LO;
                led_q[c]   <= 1'b0;
              end
              S_BLINK_LO: begin
                state_q[c] <= S_BLINK_HI;
                led_q[c]   <= 1'b1;
              end
              S_PULSE_HI: begin
                rem_q[c] <= rem_q[c] - CNT_W'(1);
                led_q[c] <= 1'b0;
                if (rem_q[c] == CNT_W'(1)) begin
                  state_q[c] <= S_OFF;
                  busy_q[c]  <= 1'b0;
                  done_q[c]  <= 1'b1;
                end else begin
                  state_q[c] <= S_PULSE_LO;
                end
              end
              S_PULSE_LO: begin
                state_q[c] <= S_PULSE_HI;
                led_q[c]   <= 1'b1;
              end
              default: begin
                state_q[c] <= state_q[c];
              end
            endcase
          end else begin
            cnt_q[c] <= cnt_q[c] + PER_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    o_state = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      o_state[3*c +: 3] = state_q[c];
    end
  end

  assign o_led  = led_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule
